// File: rtl/tron_round_ctrl.sv
// tron_round_ctrl
// Round sequencer and board-memory arbiter for the two-player Tron game.
// Steps both light-cycles once per move tick, checks each next cell against
// the shared single-port board RAM, writes trails, clears the board between
// rounds, keeps the scores and lends the board port to the VGA renderer
// whenever the game engine does not need it.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   start               level match enable
//   tick                one-cycle move pulse
//   p1_dir, p2_dir      requested direction (00 up, 01 right, 10 down, 11 left)
//   brd_addr/we/wdata   board port, address {y[4:0], x[4:0]}
//   brd_rdata           synchronous read data (valid the cycle after address)
//   disp_req/addr/gnt   renderer port request, address, grant
//   p1_x..p2_y          head positions
//   p1_score, p2_score  match scores
//   state               00 IDLE, 01 RUN, 10 ROUND_END, 11 DONE
//   round_winner        00 none, 01 P1, 10 P2, 11 draw
//
// Build option: TRON_REVERSE_GUARD_EN -- when defined, a requested direction
// exactly opposite the current one is ignored at LATCH.
module tron_round_ctrl #(
    parameter int unsigned GRID      = 25,
    parameter int unsigned WIN_SCORE = 10,
    parameter int unsigned P1_X0     = 2,
    parameter int unsigned P1_Y0     = 12,
    parameter int unsigned P2_X0     = 22,
    parameter int unsigned P2_Y0     = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tick,
    input  logic [1:0] p1_dir,
    input  logic [1:0] p2_dir,
    output logic [9:0] brd_addr,
    output logic       brd_we,
    output logic [1:0] brd_wdata,
    input  logic [1:0] brd_rdata,
    input  logic       disp_req,
    input  logic [9:0] disp_addr,
    output logic       disp_gnt,
    output logic [4:0] p1_x,
    output logic [4:0] p1_y,
    output logic [4:0] p2_x,
    output logic [4:0] p2_y,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] state,
    output logic [1:0] round_winner
);

    localparam logic [5:0] GRID6 = 6'(GRID);
    localparam logic [3:0] WIN4  = 4'(WIN_SCORE);
    localparam logic [4:0] P1X   = 5'(P1_X0);
    localparam logic [4:0] P1Y   = 5'(P1_Y0);
    localparam logic [4:0] P2X   = 5'(P2_X0);
    localparam logic [4:0] P2Y   = 5'(P2_Y0);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_SEED, S_WAIT, S_LATCH, S_RD1, S_RD2, S_CHK,
        S_WR1, S_WR2, S_ROUND_END, S_DONE
    } fsm_t;

    fsm_t       fsm, nxt;
    logic [9:0] clr_cnt;
    logic       seed_ph;
    logic [5:0] n1x, n1y, n2x, n2y;
    logic       c1_hit;
    logic [1:0] p1_eff, p2_eff;
    logic       same, crash1, crash2;
    logic [11:0] step1, step2;

    // Next cell in 6-bit arithmetic: stepping below 0 wraps to 63, which the
    // ">= GRID" test then flags as out of bounds.
    function automatic logic [11:0] step(input logic [4:0] x, input logic [4:0] y,
                                         input logic [1:0] d);
        logic [5:0] xx;
        logic [5:0] yy;
        xx = {1'b0, x};
        yy = {1'b0, y};
        case (d)
            2'b00:   yy = yy - 6'd1;
            2'b01:   xx = xx + 6'd1;
            2'b10:   yy = yy + 6'd1;
            default: xx = xx - 6'd1;
        endcase
        return {yy, xx};
    endfunction

`ifdef TRON_REVERSE_GUARD_EN
    logic [1:0] p1_d, p2_d;

    // Opposite direction differs only in bit 1.
    always_comb begin
        p1_eff = (p1_dir == (p1_d ^ 2'b10)) ? p1_d : p1_dir;
        p2_eff = (p2_dir == (p2_d ^ 2'b10)) ? p2_d : p2_dir;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_d <= 2'b01;
            p2_d <= 2'b11;
        end else if (fsm == S_SEED) begin
            p1_d <= 2'b01;
            p2_d <= 2'b11;
        end else if (fsm == S_LATCH) begin
            p1_d <= p1_eff;
            p2_d <= p2_eff;
        end
    end
`else
    always_comb begin
        p1_eff = p1_dir;
        p2_eff = p2_dir;
    end
`endif

    always_comb begin
        step1 = step(p1_x, p1_y, p1_eff);
        step2 = step(p2_x, p2_y, p2_eff);
    end

    // Valid in CHK: P1's cell was captured in RD2, P2's cell is on brd_rdata now.
    always_comb begin
        same   = (n1x == n2x) && (n1y == n2y);
        crash1 = (n1x >= GRID6) || (n1y >= GRID6) || c1_hit || same;
        crash2 = (n2x >= GRID6) || (n2y >= GRID6) || (brd_rdata != 2'b00) || same;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm          <= S_IDLE;
            clr_cnt      <= '0;
            seed_ph      <= 1'b0;
            n1x          <= '0;
            n1y          <= '0;
            n2x          <= '0;
            n2y          <= '0;
            c1_hit       <= 1'b0;
            p1_x         <= P1X;
            p1_y         <= P1Y;
            p2_x         <= P2X;
            p2_y         <= P2Y;
            p1_score     <= '0;
            p2_score     <= '0;
            round_winner <= 2'b00;
        end else begin
            fsm     <= nxt;
            clr_cnt <= (fsm == S_CLEAR) ? clr_cnt + 10'd1 : '0;
            seed_ph <= (fsm == S_SEED) ? ~seed_ph : 1'b0;
            case (fsm)
                S_IDLE: begin
                    if (start) begin
                        p1_score <= '0;
                        p2_score <= '0;
                    end
                end
                S_SEED: begin
                    p1_x         <= P1X;
                    p1_y         <= P1Y;
                    p2_x         <= P2X;
                    p2_y         <= P2Y;
                    round_winner <= 2'b00;
                end
                S_LATCH: begin
                    {n1y, n1x} <= step1;
                    {n2y, n2x} <= step2;
                end
                S_RD2: c1_hit <= (brd_rdata != 2'b00);
                S_CHK: begin
                    if (crash1 && crash2) begin
                        round_winner <= 2'b11;
                    end else if (crash1) begin
                        round_winner <= 2'b10;
                        if (p2_score < WIN4) p2_score <= p2_score + 4'd1;
                    end else if (crash2) begin
                        round_winner <= 2'b01;
                        if (p1_score < WIN4) p1_score <= p1_score + 4'd1;
                    end
                end
                S_WR2: begin
                    p1_x <= n1x[4:0];
                    p1_y <= n1y[4:0];
                    p2_x <= n2x[4:0];
                    p2_y <= n2y[4:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt = fsm;
        case (fsm)
            S_IDLE:      if (start) nxt = S_CLEAR;
            S_CLEAR:     if (clr_cnt == 10'd1023) nxt = S_SEED;
            S_SEED:      if (seed_ph) nxt = S_WAIT;
            S_WAIT:      if (tick) nxt = S_LATCH;
            S_LATCH:     nxt = S_RD1;
            S_RD1:       nxt = S_RD2;
            S_RD2:       nxt = S_CHK;
            S_CHK:       nxt = (crash1 || crash2) ? S_ROUND_END : S_WR1;
            S_WR1:       nxt = S_WR2;
            S_WR2:       nxt = S_WAIT;
            S_ROUND_END: begin
                if (p1_score == WIN4 || p2_score == WIN4) nxt = S_DONE;
                else if (tick)                            nxt = S_CLEAR;
            end
            S_DONE:      if (!start) nxt = S_IDLE;
            default:     nxt = S_IDLE;
        endcase
        // Dropping start abandons the match from any running state.
        if (!start && fsm != S_IDLE && fsm != S_DONE) nxt = S_IDLE;
    end

    always_comb begin
        brd_addr  = '0;
        brd_we    = 1'b0;
        brd_wdata = 2'b00;
        disp_gnt  = 1'b0;
        state     = 2'b01;
        case (fsm)
            S_CLEAR: begin
                brd_addr = clr_cnt;
                brd_we   = 1'b1;
            end
            S_SEED: begin
                brd_we    = 1'b1;
                brd_addr  = seed_ph ? {P2Y, P2X} : {P1Y, P1X};
                brd_wdata = seed_ph ? 2'b10 : 2'b01;
            end
            S_RD1: brd_addr = {n1y[4:0], n1x[4:0]};
            S_RD2: brd_addr = {n2y[4:0], n2x[4:0]};
            S_WR1: begin
                brd_addr  = {n1y[4:0], n1x[4:0]};
                brd_we    = 1'b1;
                brd_wdata = 2'b01;
            end
            S_WR2: begin
                brd_addr  = {n2y[4:0], n2x[4:0]};
                brd_we    = 1'b1;
                brd_wdata = 2'b10;
            end
            S_IDLE, S_WAIT, S_ROUND_END, S_DONE: begin
                disp_gnt = disp_req;
                if (disp_req) brd_addr = disp_addr;
            end
            default: ;
        endcase
        case (fsm)
            S_IDLE:      state = 2'b00;
            S_ROUND_END: state = 2'b10;
            S_DONE:      state = 2'b11;
            default:     state = 2'b01;
        endcase
    end

endmodule

// File: tb/tb_tron_round_ctrl.sv
// tb_tron_round_ctrl
// Directed bench for tron_round_ctrl with a behavioural synchronous board RAM.
module tb_tron_round_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       tick;
    logic [1:0] p1_dir, p2_dir;
    logic [9:0] brd_addr;
    logic       brd_we;
    logic [1:0] brd_wdata;
    logic [1:0] brd_rdata;
    logic       disp_req;
    logic [9:0] disp_addr;
    logic       disp_gnt;
    logic [4:0] p1_x, p1_y, p2_x, p2_y;
    logic [3:0] p1_score, p2_score;
    logic [1:0] state;
    logic [1:0] round_winner;

    int checks = 0;
    int errors = 0;
    int zero_writes = 0;
    int overlap = 0;
    int z0;

    logic [1:0] mem [0:1023];

    tron_round_ctrl #(.GRID(25), .WIN_SCORE(10), .P1_X0(2), .P1_Y0(12),
                      .P2_X0(22), .P2_Y0(12)) dut (
        .clk(clk), .reset(reset), .start(start), .tick(tick),
        .p1_dir(p1_dir), .p2_dir(p2_dir),
        .brd_addr(brd_addr), .brd_we(brd_we), .brd_wdata(brd_wdata),
        .brd_rdata(brd_rdata),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .p1_score(p1_score), .p2_score(p2_score),
        .state(state), .round_winner(round_winner)
    );

    always #5 clk = ~clk;

    // Board RAM; filled with 11 during reset so the clear pass is observable.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 2'b11;
        end else begin
            if (brd_we) mem[brd_addr] <= brd_wdata;
            if (brd_we && brd_wdata == 2'b00) zero_writes <= zero_writes + 1;
        end
        brd_rdata <= mem[brd_addr];
    end

    always @(negedge clk) begin
        if (disp_gnt && brd_we) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(8);
    endtask

    // Tick out of ROUND_END, then sit through clear and seed.
    task automatic start_round();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(1040);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; tick = 1'b0;
        p1_dir = 2'b01; p2_dir = 2'b11;
        disp_req = 1'b0; disp_addr = 10'h155;
        cyc(3);
        check("rst_state", state, 0);
        check("rst_p1_score", p1_score, 0);
        check("rst_p2_score", p2_score, 0);
        check("rst_winner", round_winner, 0);
        check("rst_p1_xy", {p1_x, p1_y}, {5'd2, 5'd12});
        check("rst_p2_xy", {p2_x, p2_y}, {5'd22, 5'd12});
        check("rst_brd", {brd_we, brd_addr, brd_wdata}, 0);
        reset = 1'b0;
        cyc(1);

        // Renderer owns the port in IDLE
        disp_req = 1'b1;
        #1;
        check("idle_gnt", disp_gnt, 1);
        check("idle_addr", brd_addr, 10'h155);
        check("idle_we", brd_we, 0);

        // Match start: clear then seed
        z0 = zero_writes;
        start = 1'b1;
        cyc(1);
        check("run_state", state, 1);
        check("clear_gnt", disp_gnt, 0);
        cyc(1039);
        check("clear_count", zero_writes - z0, 1024);
        check("seed_p1", mem[386], 1);
        check("seed_p2", mem[406], 2);
        check("clear_lo", mem[0], 0);
        check("clear_hi", mem[1023], 0);
        check("wait_gnt", disp_gnt, 1);

        // One move, latency 6 cycles from the tick edge
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        check("latch_gnt", disp_gnt, 0);
        cyc(5);
        check("move_not_yet", p1_x, 2);
        cyc(1);
        check("move_p1_x", p1_x, 3);
        check("move_p2_x", p2_x, 21);
        check("trail_p1", mem[387], 1);
        check("trail_p2", mem[405], 2);
        cyc(2);

        // P1 climbs off the top edge on the 13th upward tick
        p1_dir = 2'b00;
        repeat (12) do_tick();
        check("climb_p1_y", p1_y, 0);
        check("climb_state", state, 1);
        check("climb_p2_x", p2_x, 9);
        do_tick();
        check("oob_state", state, 2);
        check("oob_winner", round_winner, 2);
        check("oob_p2_score", p2_score, 1);
        check("oob_p1_score", p1_score, 0);
        check("oob_p1_y", p1_y, 0);

        // Head-on at x=12
        p1_dir = 2'b01; p2_dir = 2'b11;
        start_round();
        check("r2_p1_xy", {p1_x, p1_y}, {5'd2, 5'd12});
        check("r2_winner", round_winner, 0);
        check("r2_old_trail", mem[163], 0);
        repeat (9) do_tick();
        check("near_p1_x", p1_x, 11);
        check("near_p2_x", p2_x, 13);
        do_tick();
        check("draw_winner", round_winner, 3);
        check("draw_scores", {p1_score, p2_score}, {4'd0, 4'd1});
        check("draw_state", state, 2);
        check("draw_p1_x", p1_x, 11);

        // P1 wins 10 rounds: P2 goes down, then right off the edge
        for (int r = 0; r < 10; r++) begin
            p1_dir = 2'b01;
            start_round();
            p2_dir = 2'b10;
            do_tick();
            p2_dir = 2'b01;
            repeat (3) do_tick();
            if (r == 0) begin
                check("win1_score", p1_score, 1);
                check("win1_winner", round_winner, 1);
                check("win1_state", state, 2);
            end
        end
        check("done_state", state, 3);
        check("done_p1_score", p1_score, 10);
        check("done_p2_score", p2_score, 1);
        check("done_gnt", disp_gnt, 1);

        // New match: scores visible in IDLE, cleared at restart
        start = 1'b0;
        cyc(1);
        check("idle2_state", state, 0);
        check("idle2_score", p1_score, 10);
        start = 1'b1;
        cyc(1);
        check("restart_scores", {p1_score, p2_score}, 0);
        cyc(1039);
        p1_dir = 2'b01; p2_dir = 2'b11;
        do_tick();
        p1_dir = 2'b11;
        do_tick();
`ifdef TRON_REVERSE_GUARD_EN
        check("rev_p1_x", p1_x, 4);
        check("rev_state", state, 1);
        check("rev_winner", round_winner, 0);
`else
        check("rev_p1_x", p1_x, 3);
        check("rev_state", state, 2);
        check("rev_winner", round_winner, 2);
        check("rev_p2_score", p2_score, 1);
`endif

        // Reset during CLEAR drops the write strobe at once
        start = 1'b0;
        cyc(1);
        start = 1'b1;
        cyc(3);
        check("clear_we", brd_we, 1);
        reset = 1'b1;
        #1;
        check("abort_we", brd_we, 0);
        check("abort_state", state, 0);
        cyc(2);
        reset = 1'b0;
        start = 1'b0;
        cyc(2);

        check("gnt_we_overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
